nx_event_counter_array_mp: RTL

//  Multi-port successor to the single-strobe event counter array. N_PORTS event sources
//  may hit the same or different counters in one cycle, and no event is ever lost.

---
 rtl/nx_event_counter_pkg.sv | 22 ++
 rtl/nx_event_counter_update.sv | 30 +++
 rtl/nx_event_counter_array_mp.sv | 94 +++++++++
 3 files changed

// File: rtl/nx_event_counter_pkg.sv
// nx_event_counter_pkg: shared widths, counter type and the saturate/wrap adder
package nx_event_counter_pkg;
  localparam int MAX_W = 128;
  localparam int CNT_W = 32;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [MAX_W-1:0] wide_t;
  function automatic int inc_w(input int by_bits, input int ports);
    return by_bits + $clog2(ports);
  endfunction
  function automatic int add_w(input int cnt_bits);
    return cnt_bits + 1;
  endfunction
  // Returns {carry,result} packed in the low w+1 bits; operands must fit in w bits
  function automatic logic [MAX_W:0] sat_add(input wide_t a, input wide_t b, input int w,
                                             input logic saturate);
    logic [MAX_W:0] s, mask, top;
    s = {1'b0, a} + {1'b0, b};
    top = (MAX_W+1)'(1) << w;
    mask = top - (MAX_W+1)'(1);
    return (s & ~mask) != '0 ? top | (saturate ? mask : s & mask) : s;
  endfunction
endpackage

// File: rtl/nx_event_counter_update.sv
// nx_event_counter_update: sums matching port increments onto a base value for one counter
module nx_event_counter_update
  import nx_event_counter_pkg::*;
#(
  parameter int ID              = 0,
  parameter int N_PORTS         = 2,
  parameter int N_COUNT_BY_BITS = 4,
  parameter int N_ID_BITS       = 3,
  parameter int N_COUNTER_BITS  = 32,
  parameter int SATURATE        = 1
) (
  input  logic [N_PORTS-1:0]                 count_stb_i,
  input  logic [N_PORTS*N_COUNT_BY_BITS-1:0] count_by_i,
  input  logic [N_PORTS*N_ID_BITS-1:0]       count_id_i,
  input  logic [N_COUNTER_BITS-1:0]          base_i,
  output logic [N_COUNTER_BITS-1:0]          next_o,
  output logic                               carry_o
);
  localparam int INC_W = inc_w(N_COUNT_BY_BITS, N_PORTS);
  localparam int AW    = add_w(N_COUNTER_BITS);
  logic [INC_W-1:0] inc;
  always_comb begin
    inc = '0;
    for (int p = 0; p < N_PORTS; p++)
      if (count_stb_i[p] && count_id_i[p*N_ID_BITS +: N_ID_BITS] == N_ID_BITS'(ID))
        inc = inc + INC_W'(count_by_i[p*N_COUNT_BY_BITS +: N_COUNT_BY_BITS]);
  end
  assign {carry_o, next_o} = AW'(sat_add(wide_t'(base_i), wide_t'(inc), N_COUNTER_BITS,
                                         SATURATE != 0));
endmodule

// File: rtl/nx_event_counter_array_mp.sv
// nx_event_counter_array_mp: multi-port event counter array with CSR read/clear, write
// and coherent global snapshot
module nx_event_counter_array_mp
  import nx_event_counter_pkg::*;
#(
  parameter int BASE_ADDRESS    = 0,
  parameter int ALIGNMENT       = 2,
  parameter int N_ADDR_BITS     = 16,
  parameter int N_COUNTERS      = 8,
  parameter int N_PORTS         = 2,
  parameter int N_COUNT_BY_BITS = 4,
  parameter int N_COUNTER_BITS  = CNT_W,
  parameter int SATURATE        = 1,
  parameter int CLEAR_ON_READ   = 1,
  localparam int IW = N_COUNTERS > 1 ? $clog2(N_COUNTERS) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [N_ADDR_BITS-1:0]               reg_addr,
  input  logic                                 rd_stb,
  input  logic                                 wr_stb,
  input  logic [N_COUNTER_BITS-1:0]            reg_data,
  input  logic                                 snapshot_mode,
  input  logic [N_PORTS-1:0]                   count_stb,
  input  logic [N_PORTS*N_COUNT_BY_BITS-1:0]   count_by,
  input  logic [N_PORTS*IW-1:0]                count_id,
  output logic [N_COUNTER_BITS-1:0]            rd_data,
  output logic                                 rd_ack,
  output logic [N_COUNTERS-1:0]                overflow,
  output logic [N_COUNTERS*N_COUNTER_BITS-1:0] counter_a
);
  localparam int W = N_COUNTER_BITS;
  localparam logic [N_ADDR_BITS:0] LO   = (N_ADDR_BITS+1)'(BASE_ADDRESS);
  localparam logic [N_ADDR_BITS:0] SPAN = (N_ADDR_BITS+1)'(N_COUNTERS << ALIGNMENT);
  logic [W-1:0] cnt_q [N_COUNTERS];
  logic [W-1:0] base [N_COUNTERS];
  logic [W-1:0] nxt [N_COUNTERS];
  logic [N_COUNTERS-1:0] carry, clr, ovf_q, ovf_d;
  logic [N_ADDR_BITS:0] diff;
  logic [IW-1:0] idx;
  logic sel, glob, rd_cnt, rd_glob, wr;
  logic [W-1:0] rd_data_q, rd_data_d;
  logic rd_ack_q, rd_ack_d;
  logic [N_COUNTERS*W-1:0] ca_q, ca_d;
  // An address below BASE underflows into the extra top bit and is never selected
  assign diff    = {1'b0, reg_addr} - LO;
  assign sel     = !diff[N_ADDR_BITS] && diff < SPAN;
  assign glob    = diff == SPAN;
  assign idx     = IW'(diff >> ALIGNMENT);
  assign rd_cnt  = rd_stb && sel && !snapshot_mode;
  assign rd_glob = rd_stb && glob && snapshot_mode;
  assign wr      = wr_stb && sel && !rd_stb;
  for (genvar i = 0; i < N_COUNTERS; i++) begin : g_cnt
    logic hit, rd_clr;
    assign hit     = idx == IW'(i);
    assign rd_clr  = rd_glob || (rd_cnt && CLEAR_ON_READ != 0 && hit);
    assign clr[i]  = rd_clr || (wr && hit);
    assign base[i] = rd_clr ? '0 : (wr && hit) ? reg_data : cnt_q[i];
    nx_event_counter_update #(
      .ID(i), .N_PORTS(N_PORTS), .N_COUNT_BY_BITS(N_COUNT_BY_BITS), .N_ID_BITS(IW),
      .N_COUNTER_BITS(W), .SATURATE(SATURATE)
    ) u_upd (
      .count_stb_i(count_stb), .count_by_i(count_by), .count_id_i(count_id),
      .base_i(base[i]), .next_o(nxt[i]), .carry_o(carry[i])
    );
  end
  // A carry in the same cycle as a clear leaves the flag set
  assign ovf_d     = carry | (ovf_q & ~clr);
  assign rd_ack_d  = rd_cnt || rd_glob;
  assign rd_data_d = rd_glob ? W'(ovf_q) : rd_cnt ? cnt_q[idx] : rd_data_q;
  always_comb begin
    ca_d = ca_q;
    for (int i = 0; i < N_COUNTERS; i++)
      if (!snapshot_mode || rd_glob) ca_d[i*W +: W] = cnt_q[i];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < N_COUNTERS; i++) cnt_q[i] <= '0;
      ovf_q     <= '0;
      rd_data_q <= '0;
      rd_ack_q  <= 1'b0;
      ca_q      <= '0;
    end else begin
      for (int i = 0; i < N_COUNTERS; i++) cnt_q[i] <= nxt[i];
      ovf_q     <= ovf_d;
      rd_data_q <= rd_data_d;
      rd_ack_q  <= rd_ack_d;
      ca_q      <= ca_d;
    end
  assign rd_data   = rd_data_q;
  assign rd_ack    = rd_ack_q;
  assign overflow  = ovf_q;
  assign counter_a = ca_q;
endmodule
